// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone arbiter in front of one memory port: a one-deep request slot per master,
// round-robin grant, one transaction in flight, and a bounded wait that turns a hung slave into an error ack.
module wb_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_stb,
    input  logic        i_m0_we,
    input  logic [2:0]  i_m0_sel,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    output logic        o_m0_stall,
    output logic        o_m0_ack,
    output logic        o_m0_err,
    output logic [31:0] o_m0_data,
    input  logic        i_m1_stb,
    input  logic        i_m1_we,
    input  logic [2:0]  i_m1_sel,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    output logic        o_m1_stall,
    output logic        o_m1_ack,
    output logic        o_m1_err,
    output logic [31:0] o_m1_data,
    output logic        o_s_stb,
    output logic        o_s_we,
    output logic [2:0]  o_s_sel,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_data,
    input  logic        i_s_stall,
    input  logic        i_s_ack,
    input  logic [31:0] i_s_data,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Handshake: a master strobe is taken when its slot is empty (stall low) and it is not
    // in its own ack cycle; the slave strobe is a single-cycle pulse qualified by !i_s_stall.
    logic [1:0]  stb;
    logic [67:0] req [2];
    logic [67:0] slot_q [2];
    logic [1:0]  slot_valid_q;
    logic [1:0]  slot_clr;

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic        s_stb_q, s_stb_d;
    logic [67:0] s_fields_q, s_fields_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata_q [2];
    logic [31:0] rdata_d [2];

    assign stb    = {i_m1_stb, i_m0_stb};
    assign req[0] = {i_m0_we, i_m0_sel, i_m0_addr, i_m0_data};
    assign req[1] = {i_m1_we, i_m1_sel, i_m1_addr, i_m1_data};

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        s_stb_d      = 1'b0;
        s_fields_d   = s_fields_q;
        ack_d        = 2'b00;
        err_d        = 2'b00;
        rdata_d[0]   = rdata_q[0];
        rdata_d[1]   = rdata_q[1];
        slot_clr     = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (|slot_valid_q) begin
                    // On a tie the master that was not served last wins.
                    if (&slot_valid_q) grant_d = ~last_grant_q;
                    else               grant_d = slot_valid_q[1];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!i_s_stall) begin
                    s_stb_d    = 1'b1;
                    s_fields_d = slot_q[grant_q];
                    cnt_d      = 16'd0;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (i_s_ack) begin
                    rdata_d[grant_q] = i_s_data;
                    ack_d[grant_q]   = 1'b1;
                    slot_clr[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d[grant_q] = 32'hFFFF_FFFF;
                    ack_d[grant_q]   = 1'b1;
                    err_d[grant_q]   = 1'b1;
                    slot_clr[grant_q] = 1'b1;
                    last_grant_d     = grant_q;
                    state_d          = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 16'd0;
            s_stb_q      <= 1'b0;
            s_fields_q   <= '0;
            ack_q        <= 2'b00;
            err_q        <= 2'b00;
            rdata_q[0]   <= '0;
            rdata_q[1]   <= '0;
            slot_valid_q <= 2'b00;
            slot_q[0]    <= '0;
            slot_q[1]    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            s_stb_q      <= s_stb_d;
            s_fields_q   <= s_fields_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q[0]   <= rdata_d[0];
            rdata_q[1]   <= rdata_d[1];
            for (int n = 0; n < 2; n++) begin
                if (slot_clr[n]) begin
                    slot_valid_q[n] <= 1'b0;
                end else if (stb[n] && !slot_valid_q[n] && !ack_q[n]) begin
                    slot_valid_q[n] <= 1'b1;
                    slot_q[n]       <= req[n];
                end
            end
        end
    end

    assign o_m0_stall = slot_valid_q[0];
    assign o_m0_ack   = ack_q[0];
    assign o_m0_err   = err_q[0];
    assign o_m0_data  = rdata_q[0];
    assign o_m1_stall = slot_valid_q[1];
    assign o_m1_ack   = ack_q[1];
    assign o_m1_err   = err_q[1];
    assign o_m1_data  = rdata_q[1];
    assign o_s_stb    = s_stb_q;
    assign {o_s_we, o_s_sel, o_s_addr, o_s_data} = s_fields_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: directed latency/arbitration/timeout/reset cases, then two random
// masters against a behavioural slave whose chosen responses form the expected queues.
module tb_wb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_m0_stb, i_m0_we, i_m1_stb, i_m1_we;
    logic [2:0]  i_m0_sel, i_m1_sel;
    logic [31:0] i_m0_addr, i_m0_data, i_m1_addr, i_m1_data;
    logic        o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err;
    logic [31:0] o_m0_data, o_m1_data;
    logic        o_s_stb, o_s_we;
    logic [2:0]  o_s_sel;
    logic [31:0] o_s_addr, o_s_data;
    logic        i_s_stall, i_s_ack;
    logic [31:0] i_s_data;
    logic [1:0]  o_dbg_state;

    wb_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we), .i_m0_sel(i_m0_sel),
        .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data),
        .o_m0_stall(o_m0_stall), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_data(o_m0_data),
        .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we), .i_m1_sel(i_m1_sel),
        .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data),
        .o_m1_stall(o_m1_stall), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_data(o_m1_data),
        .o_s_stb(o_s_stb), .o_s_we(o_s_we), .o_s_sel(o_s_sel),
        .o_s_addr(o_s_addr), .o_s_data(o_s_data),
        .i_s_stall(i_s_stall), .i_s_ack(i_s_ack), .i_s_data(i_s_data),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- clock / reset / monitors ----------------
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stb_cnt = 0;
    int ack_cnt0 = 0;

    always @(posedge i_clk) begin
        cyc++;
        if (o_s_stb) stb_cnt++;
        if (o_m0_ack) ack_cnt0++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    logic [67:0] pend_f [2];
    logic        pend [2];
    logic        done [2];
    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        repeat (2) tick();
        i_reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m"}, {o_m0_stall, o_m0_ack, o_m0_err, o_m1_stall, o_m1_ack, o_m1_err,
                            o_m0_data, o_m1_data}, 72'd0);
        check({tag, "_s"}, {o_s_stb, o_s_we, o_s_sel, o_s_addr, o_s_data, o_dbg_state}, 72'd0);
    endtask

    task automatic wait_sstb(input string tag);
        int k;
        k = 0;
        while (!o_s_stb && k < 40) begin
            tick();
            k++;
        end
        check(tag, o_s_stb, 1);
    endtask

    // Slave side: wait for the strobe, ack after 'delay' extra cycles; returns in the master ack cycle.
    task automatic serve(input string tag, input int delay, input logic [31:0] rdata);
        wait_sstb(tag);
        repeat (delay) tick();
        i_s_ack  = 1'b1;
        i_s_data = rdata;
        tick();
        i_s_ack  = 1'b0;
    endtask

    task automatic m0_req(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] data);
        i_m0_we = we; i_m0_sel = sel; i_m0_addr = addr; i_m0_data = data; i_m0_stb = 1'b1;
    endtask

    task automatic m1_req(input logic we, input logic [2:0] sel, input logic [31:0] addr,
                          input logic [31:0] data);
        i_m1_we = we; i_m1_sel = sel; i_m1_addr = addr; i_m1_data = data; i_m1_stb = 1'b1;
    endtask

    task automatic rnd_master(input int n);
        logic [31:0] a, d;
        logic [67:0] f;
        logic [32:0] e;
        logic        got_ack;
        logic [32:0] got;
        int k;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(1, 4)) tick();
            a = $urandom();
            a[31] = n[0];
            d = $urandom();
            f = {1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, d};
            pend_f[n] = f;
            pend[n] = 1'b1;
            if (n == 0) begin
                m0_req(f[67], f[66:64], f[63:32], f[31:0]);
                tick();
                i_m0_stb = 1'b0;
            end else begin
                m1_req(f[67], f[66:64], f[63:32], f[31:0]);
                tick();
                i_m1_stb = 1'b0;
            end
            k = 0;
            got_ack = (n == 0) ? o_m0_ack : o_m1_ack;
            while (!got_ack && k < 80) begin
                tick();
                k++;
                got_ack = (n == 0) ? o_m0_ack : o_m1_ack;
            end
            check("rnd_ack_seen", got_ack, 1);
            got = (n == 0) ? {o_m0_err, o_m0_data} : {o_m1_err, o_m1_data};
            if (n == 0 && exp_q0.size() > 0) begin
                e = exp_q0.pop_front();
                check("rnd_resp0", got, e);
            end else if (n == 1 && exp_q1.size() > 0) begin
                e = exp_q1.pop_front();
                check("rnd_resp1", got, e);
            end else begin
                check("rnd_expq_empty", got_ack, 0);
            end
            pend[n] = 1'b0;
        end
        done[n] = 1'b1;
    endtask

    task automatic rnd_slave();
        int mode, d;
        logic owner;
        logic [31:0] rd;
        while (!(done[0] && done[1])) begin
            tick();
            i_s_ack = 1'b0;
            i_s_stall = ($urandom_range(0, 3) == 0);
            if (o_s_stb) begin
                owner = o_s_addr[31];
                check("rnd_pend", pend[owner], 1);
                check("rnd_fields", {o_s_we, o_s_sel, o_s_addr, o_s_data}, pend_f[owner]);
                mode = $urandom_range(0, 7);
                if (mode == 0) begin
                    if (owner) exp_q1.push_back({1'b1, 32'hFFFF_FFFF});
                    else       exp_q0.push_back({1'b1, 32'hFFFF_FFFF});
                    repeat (8) begin
                        tick();
                        i_s_stall = ($urandom_range(0, 3) == 0);
                    end
                end else begin
                    d = $urandom_range(0, 5);
                    repeat (d) begin
                        tick();
                        i_s_stall = ($urandom_range(0, 3) == 0);
                    end
                    rd = $urandom();
                    if (owner) exp_q1.push_back({1'b0, rd});
                    else       exp_q0.push_back({1'b0, rd});
                    i_s_ack = 1'b1;
                    i_s_data = rd;
                    tick();
                    i_s_ack = 1'b0;
                end
            end else if ($urandom_range(0, 9) == 0) begin
                // Stray ack outside a transaction must be ignored.
                i_s_ack = 1'b1;
                i_s_data = $urandom();
            end
        end
        i_s_ack = 1'b0;
        i_s_stall = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int s0, t0, k, a0;
        i_reset = 1'b1;
        i_m0_stb = 0; i_m0_we = 0; i_m0_sel = 0; i_m0_addr = 0; i_m0_data = 0;
        i_m1_stb = 0; i_m1_we = 0; i_m1_sel = 0; i_m1_addr = 0; i_m1_data = 0;
        i_s_stall = 0; i_s_ack = 0; i_s_data = 0;
        pend[0] = 0; pend[1] = 0; done[0] = 0; done[1] = 0;
        pend_f[0] = '0; pend_f[1] = '0;
        repeat (3) tick();
        check_all_zero("reset");
        i_reset = 1'b0;
        tick();

        // 1: single M0 read, slave acks one cycle after the strobe
        m0_req(1'b0, 3'd2, 32'h10, 32'h0);
        tick();
        i_m0_stb = 1'b0;
        check("t1_stall", o_m0_stall, 1);
        tick();
        check("t1_no_stb_yet", o_s_stb, 0);
        tick();
        check("t1_s_stb", {o_s_stb, o_s_we, o_s_sel, o_s_addr}, {1'b1, 1'b0, 3'd2, 32'h10});
        tick();
        check("t1_stb_pulse", o_s_stb, 0);
        i_s_ack = 1'b1;
        i_s_data = 32'hDEAD_BEEF;
        tick();
        i_s_ack = 1'b0;
        check("t1_ack", {o_m0_ack, o_m0_err, o_m0_data}, {1'b1, 1'b0, 32'hDEAD_BEEF});
        check("t1_m1_quiet", {o_m1_ack, o_m1_err, o_m1_stall}, 0);
        check("t1_addr_held", o_s_addr, 32'h10);
        tick();
        check("t1_ack_pulse", {o_m0_ack, o_m0_stall, o_m0_data}, {2'b00, 32'hDEAD_BEEF});

        // 2: simultaneous requests, four rounds, M0 first every round
        do_reset();
        for (int r = 0; r < 4; r++) begin
            m0_req(1'b0, 3'd2, 32'h100, 32'h0);
            m1_req(1'b0, 3'd2, 32'h200, 32'h0);
            tick();
            i_m0_stb = 1'b0;
            i_m1_stb = 1'b0;
            serve("t2_first_stb", 0, 32'hA000 + r);
            check("t2_first_addr", o_s_addr, 32'h100);
            check("t2_first_ack", {o_m0_ack, o_m1_ack, o_m0_data}, {2'b10, 32'hA000 + r});
            serve("t2_second_stb", 0, 32'hB000 + r);
            check("t2_second_addr", o_s_addr, 32'h200);
            check("t2_second_ack", {o_m0_ack, o_m1_ack, o_m1_data}, {2'b01, 32'hB000 + r});
            tick();
        end

        // 3: M1 write held off by slave stall
        i_s_stall = 1'b1;
        s0 = stb_cnt;
        m1_req(1'b1, 3'd2, 32'h40, 32'h55);
        tick();
        i_m1_stb = 1'b0;
        repeat (5) tick();
        check("t3_stalled", {o_s_stb, 32'(stb_cnt - s0)}, 0);
        i_s_stall = 1'b0;
        serve("t3_stb", 1, 32'h0);
        check("t3_fields", {o_s_we, o_s_sel, o_s_addr, o_s_data}, {1'b1, 3'd2, 32'h40, 32'h55});
        check("t3_ack", {o_m1_ack, o_m1_err}, 2'b10);
        repeat (3) tick();
        check("t3_once", stb_cnt - s0, 1);

        // 4: slave never acks -> error ack exactly TIMEOUT_CYCLES after strobe
        m0_req(1'b0, 3'd2, 32'h20, 32'h0);
        tick();
        i_m0_stb = 1'b0;
        wait_sstb("t4_stb");
        t0 = cyc;
        k = 0;
        while (!o_m0_ack && k < 30) begin
            tick();
            k++;
        end
        check("t4_latency", cyc - t0, 8);
        check("t4_err_ack", {o_m0_ack, o_m0_err, o_m0_data}, {2'b11, 32'hFFFF_FFFF});
        tick();
        m0_req(1'b0, 3'd2, 32'h24, 32'h0);
        tick();
        i_m0_stb = 1'b0;
        serve("t4_next_stb", 0, 32'h1234);
        check("t4_next_ack", {o_m0_ack, o_m0_err, o_m0_data}, {2'b10, 32'h1234});
        tick();

        // 5: strobe held through the ack cycle is not recaptured
        s0 = stb_cnt;
        m0_req(1'b0, 3'd2, 32'h80, 32'h0);
        serve("t5_stb", 2, 32'hCAFE);
        check("t5_ack", {o_m0_ack, o_m0_data}, {1'b1, 32'hCAFE});
        tick();
        i_m0_stb = 1'b0;
        check("t5_no_recapture", o_m0_stall, 0);
        repeat (4) tick();
        check("t5_one_txn", stb_cnt - s0, 1);

        // 6: reset while waiting for the slave ack
        m0_req(1'b0, 3'd2, 32'h30, 32'h0);
        tick();
        i_m0_stb = 1'b0;
        wait_sstb("t6_stb");
        tick();
        a0 = ack_cnt0;
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check_all_zero("t6_after_reset");
        i_s_ack = 1'b1;
        i_s_data = 32'h9999;
        tick();
        i_s_ack = 1'b0;
        repeat (3) tick();
        check("t6_no_ack", ack_cnt0 - a0, 0);
        check_all_zero("t6_late_ack");

        // random: two masters against a behavioural slave
        fork
            rnd_master(0);
            rnd_master(1);
            rnd_slave();
        join
        check("rnd_q_drained", {exp_q0.size(), exp_q1.size()}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
